counter_dec_sched: RTL and testbench
====================================

# counter_dec_sched

Round-robin scheduler that shares one cascaded decimal counter (a chain of DIGITS single-digit up/down counters, carry/borrow rippled digit to digit) between N_REQ requesters. Each request is a single increment or decrement. The block serialises requests and drives a single-cycle plus/minus pulse into the least-significant digit. It then holds off until the carry ripple has settled across all digits. It also sequences preset reload of the chain by pulsing the counters' reset and waiting for their start-up load to complete.

## Interface
- N_REQ, 4: number of requesters, 2..8.
- DIGITS, 4: digits in the counter chain, 1..8. The settle time is fixed as SETTLE = 2*DIGITS cycles.
- i_clk  in  1  clock.
- i_rst  in  1  reset, synchronous, active-high; clock i_clk.
- i_req  in  N_REQ  per-requester request level; held until the matching o_ack.
- i_dir  in  N_REQ  per-requester direction: 1 = plus, 0 = minus. Stable while i_req is high.
- o_ack  out  N_REQ  one-hot, 1-cycle acknowledge of the served request.
- i_load  in  1  preset reload request; sampled only in IDLE.
- o_load_done  out  1  1-cycle pulse when the reload (or the post-reset wait) completes.
- o_cnt_rst  out  1  reset to every digit counter, 1-cycle pulse.
- o_plus  out  1  increment pulse to digit 0.
- o_minus  out  1  decrement pulse to digit 0.
- i_zero_all  in  1  AND of all digits' zero flags.
- o_drop  out  1  1-cycle pulse: the served request was suppressed (saturation).
- o_busy  out  1  high whenever the state is not IDLE.

## Operation
- States are IDLE, ISSUE, SETTLE, LOAD and LOAD_WAIT.
- **IDLE**
  - If i_load = 1, go to LOAD. i_load has priority over all i_req.
  - Otherwise, if any i_req bit is set, register the round-robin winner and its i_dir, then go to ISSUE.
  - Otherwise stay in IDLE.
- **Round-robin arbitration**
  - The search starts at (last_winner+1) mod N_REQ and the first set bit wins.
  - last_winner resets to N_REQ-1, so requester 0 has top priority first.
  - last_winner is updated only in ISSUE.
- **ISSUE** (1 cycle)
  - o_ack[winner] = 1.
  - o_plus = dir, or o_minus = !dir; exactly one of the two is high unless the request is dropped.
  - Load the settle counter with SETTLE-1, then go to SETTLE.
- **SETTLE**
  - Decrement the settle counter each cycle.
  - Go to IDLE in the cycle after it reads 0, giving SETTLE cycles in SETTLE.
- **LOAD** (1 cycle): o_cnt_rst = 1, then go to LOAD_WAIT with the wait counter = 1.
- **LOAD_WAIT** (2 cycles): the counters pass START, where they load their presets, and reach IDLE. On the last cycle o_load_done = 1, then go to IDLE.
- **Requests during busy states**: requests arriving in any non-IDLE state are held by their requester, never lost, and served later.
- **Output rules**
  - o_plus, o_minus, o_ack, o_cnt_rst, o_drop and o_load_done are all registered.
  - They are never high together except the o_ack/o_plus and o_ack/o_minus pairs, and o_ack/o_drop.

## Timing
- **Reset values**: o_ack = 0, o_plus = o_minus = o_drop = o_cnt_rst = 0, and o_load_done = 0 during reset.
- **After reset**
  - The state goes to LOAD_WAIT (wait counter = 1) and o_busy = 1, covering the counters' own START cycle.
  - o_load_done pulses on the 2nd cycle after i_rst falls; IDLE follows on the 3rd.
- **Request latency**: i_req rises in IDLE at cycle t, so ISSUE with o_ack and the pulse is at t+1.
- **Issue spacing**: with pulses at cycle c, the next ISSUE is no earlier than c+SETTLE+2. This exceeds the worst-case ripple of 2*DIGITS+1 cycles.
- **Reload**: i_load seen in IDLE at t gives o_cnt_rst at t+1 and o_load_done at t+3.
  - The requester must drop i_load by t+3, otherwise a second reload starts.
- **Reset mid-operation**: i_rst overrides all states. Any in-flight ISSUE or SETTLE is abandoned and no ack is sent; the requester keeps i_req high and is served after reset.
- **Simultaneous i_load and i_req in IDLE**: the load wins and the requests wait.

## Configuration
- Macro: COUNTER_DEC_SCHED_SAT_EN.
- **Defined**:
  - In ISSUE, if dir = minus and i_zero_all = 1, o_minus stays 0 and o_drop = 1.
  - o_ack still pulses and SETTLE still runs, so spacing is unchanged.
  - The chain saturates at 0.
- **Undefined**:
  - o_drop is tied 0 and the minus is always issued, so the chain wraps 0…0 to 9…9.
  - i_zero_all is unused.

## Test plan
All scenarios use N_REQ=4 and DIGITS=2 (SETTLE=4).
- **Post-reset load**: release i_rst at cycle 0 with i_req held at 0001 → o_load_done at cycle 2, o_ack=0001 with o_plus at cycle 4.
- **Round-robin**: hold i_req=1111 from IDLE → ack order 0,1,2,3,0, with consecutive acks exactly 6 cycles apart.
- **Direction**: req[2] with dir=0 → o_minus=1 and o_plus=0 in the ack cycle. With a chain preset of 10, the chain reads 09 after settle.
- **Load priority**: i_load=1 and i_req=0010 in the same IDLE cycle → o_cnt_rst first, o_load_done 2 cycles later, o_ack=0010 two cycles after that.
- **Saturation**: chain at 00, i_zero_all=1, minus request.
  - With COUNTER_DEC_SCHED_SAT_EN: o_ack and o_drop=1, o_minus=0, chain stays 00.
  - Without it: o_minus=1 and the chain reads 99.
- **Mid-operation reset**: assert i_rst during SETTLE → all outputs go to 0 next cycle. The held request is acked 4 cycles after i_rst falls.

Source files
------------

// File: rtl/counter_dec_sched.sv
// Round-robin scheduler sharing one cascaded decimal up/down counter chain between N_REQ requesters.
// Optional saturation at zero is enabled by defining COUNTER_DEC_SCHED_SAT_EN.
module counter_dec_sched #(
    parameter int N_REQ  = 4,
    parameter int DIGITS = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [N_REQ-1:0] i_req,
    input  logic [N_REQ-1:0] i_dir,
    output logic [N_REQ-1:0] o_ack,
    input  logic             i_load,
    output logic             o_load_done,
    output logic             o_cnt_rst,
    output logic             o_plus,
    output logic             o_minus,
    input  logic             i_zero_all,
    output logic             o_drop,
    output logic             o_busy
);

    localparam int SETTLE = 2 * DIGITS;
    localparam int WW     = $clog2(N_REQ);
    localparam int CW     = $clog2(SETTLE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_SETTLE,
        S_LOAD,
        S_LOAD_WAIT
    } state_e;

    state_e           state_q, state_d;
    logic [WW-1:0]    last_q, last_d;
    logic [WW-1:0]    win_q, win_d;
    logic [CW-1:0]    settle_q, settle_d;
    logic             wait_q, wait_d;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic             plus_q, plus_d;
    logic             minus_q, minus_d;
    logic             drop_q, drop_d;
    logic             cnt_rst_q, cnt_rst_d;
    logic             load_done_q, load_done_d;

    logic             found;
    logic [WW-1:0]    pick;
    logic             sat;
    int               idx;

`ifdef COUNTER_DEC_SCHED_SAT_EN
    assign sat = i_zero_all;
`else
    logic unused_zero_all;
    assign unused_zero_all = i_zero_all;
    assign sat             = 1'b0;
`endif

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d     = state_q;
        last_d      = last_q;
        win_d       = win_q;
        settle_d    = settle_q;
        wait_d      = wait_q;
        ack_d       = '0;
        plus_d      = 1'b0;
        minus_d     = 1'b0;
        drop_d      = 1'b0;
        cnt_rst_d   = 1'b0;
        load_done_d = 1'b0;
        found       = 1'b0;
        pick        = win_q;
        idx         = 0;

        // Search from the requester after the last winner; first set bit wins.
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(last_q) + 1 + k) % N_REQ;
            if (!found && i_req[idx]) begin
                found = 1'b1;
                pick  = WW'(idx);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (i_load) begin
                    state_d   = S_LOAD;
                    cnt_rst_d = 1'b1;
                end else if (found) begin
                    state_d = S_ISSUE;
                    win_d   = pick;
                    ack_d   = N_REQ'(1) << pick;
                    plus_d  = i_dir[pick];
                    minus_d = !i_dir[pick] && !sat;
                    drop_d  = !i_dir[pick] && sat;
                end
            end
            S_ISSUE: begin
                last_d   = win_q;
                settle_d = CW'(SETTLE - 1);
                state_d  = S_SETTLE;
            end
            S_SETTLE: begin
                if (settle_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    settle_d = settle_q - 1'b1;
                end
            end
            S_LOAD: begin
                state_d = S_LOAD_WAIT;
                wait_d  = 1'b1;
            end
            S_LOAD_WAIT: begin
                if (wait_q) begin
                    wait_d      = 1'b0;
                    load_done_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Reset parks in LOAD_WAIT so the counters' own start-up load is covered.
    always_ff @(posedge i_clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (i_rst) begin
            state_q     <= S_LOAD_WAIT;
            last_q      <= WW'(N_REQ - 1);
            win_q       <= '0;
            settle_q    <= '0;
            wait_q      <= 1'b1;
            ack_q       <= '0;
            plus_q      <= 1'b0;
            minus_q     <= 1'b0;
            drop_q      <= 1'b0;
            cnt_rst_q   <= 1'b0;
            load_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            win_q       <= win_d;
            settle_q    <= settle_d;
            wait_q      <= wait_d;
            ack_q       <= ack_d;
            plus_q      <= plus_d;
            minus_q     <= minus_d;
            drop_q      <= drop_d;
            cnt_rst_q   <= cnt_rst_d;
            load_done_q <= load_done_d;
        end
    end

    assign o_ack       = ack_q;
    assign o_plus      = plus_q;
    assign o_minus     = minus_q;
    assign o_drop      = drop_q;
    assign o_cnt_rst   = cnt_rst_q;
    assign o_load_done = load_done_q;
    assign o_busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_counter_dec_sched.sv
// Randomized bench for counter_dec_sched: a timeline model predicts every output pulse by cycle
// number and an arithmetic model of the decimal chain tracks the expected count.
module tb_counter_dec_sched;

    localparam int N_REQ  = 4;
    localparam int DIGITS = 2;
    localparam int SETTLE = 2 * DIGITS;
    localparam int MOD    = 10 ** DIGITS;
    localparam int PRESET = 10;
    localparam int NCYC   = 3000;
    localparam int MAXC   = 4096;
    localparam int INF    = 1 << 30;
`ifdef COUNTER_DEC_SCHED_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic             i_clk = 1'b0;
    logic             i_rst;
    logic [N_REQ-1:0] i_req;
    logic [N_REQ-1:0] i_dir;
    logic [N_REQ-1:0] o_ack;
    logic             i_load;
    logic             o_load_done;
    logic             o_cnt_rst;
    logic             o_plus;
    logic             o_minus;
    logic             i_zero_all;
    logic             o_drop;
    logic             o_busy;

    counter_dec_sched #(.N_REQ(N_REQ), .DIGITS(DIGITS)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_req       (i_req),
        .i_dir       (i_dir),
        .o_ack       (o_ack),
        .i_load      (i_load),
        .o_load_done (o_load_done),
        .o_cnt_rst   (o_cnt_rst),
        .o_plus      (o_plus),
        .o_minus     (o_minus),
        .i_zero_all  (i_zero_all),
        .o_drop      (o_drop),
        .o_busy      (o_busy)
    );

    always #5 i_clk = ~i_clk;

    // Expected pulses indexed by the cycle they must appear in.
    bit [N_REQ-1:0] exp_ack     [MAXC];
    bit             exp_plus    [MAXC];
    bit             exp_minus   [MAXC];
    bit             exp_drop    [MAXC];
    bit             exp_cnt_rst [MAXC];
    bit             exp_done    [MAXC];

    int             ch;        // chain value as the counters would hold it
    int             ech;       // chain value the scheduler rules predict
    int             idle_at;   // first cycle the scheduler is expected back in IDLE
    int             last;
    int             cyc;
    int             n_cmp;
    int             n_bad;
    int             rst_left;
    int             w;
    int             idx;
    bit             rst_prev;
    bit             rst_next;
    bit             load_v;
    bit [N_REQ-1:0] req_v;
    bit [N_REQ-1:0] dir_v;

    assign i_zero_all = (ch == 0);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        ch       = PRESET;
        ech      = PRESET;
        last     = N_REQ - 1;
        idle_at  = INF;
        rst_left = 2;
        load_v   = 1'b0;
        req_v    = 4'b0001;
        dir_v    = 4'b0001;
        i_rst    = 1'b1;
        i_load   = load_v;
        i_req    = req_v;
        i_dir    = dir_v;

        for (int n = 0; n < NCYC; n++) begin
            @(posedge i_clk);
            #1;
            cyc = n;

            check("ack", o_ack, exp_ack[n]);
            check("plus", o_plus, exp_plus[n]);
            check("minus", o_minus, exp_minus[n]);
            check("drop", o_drop, exp_drop[n]);
            check("cnt_rst", o_cnt_rst, exp_cnt_rst[n]);
            check("load_done", o_load_done, exp_done[n]);
            check("busy", o_busy, n < idle_at);

            // The chain reacts to what the DUT actually drove.
            if (o_cnt_rst)     ch = PRESET;
            else if (o_plus)   ch = (ch + 1) % MOD;
            else if (o_minus)  ch = (ch + MOD - 1) % MOD;
            if (n >= idle_at) check("chain", ch, ech);

            // Requesters drop on their ack and otherwise raise new requests.
            for (int i = 0; i < N_REQ; i++) begin
                if (exp_ack[n][i]) begin
                    req_v[i] = 1'b0;
                end else if (!req_v[i] && n >= 6 &&
                             (n < 80 || $urandom_range(0, 3) == 0)) begin
                    req_v[i] = 1'b1;
                    if (n >= 1500 && n < 2500) dir_v[i] = ($urandom_range(0, 7) == 0);
                    else                       dir_v[i] = 1'($urandom_range(0, 1));
                end
            end
            if (exp_cnt_rst[n])                                          load_v = 1'b0;
            else if (!load_v && n >= 100 && $urandom_range(0, 49) == 0) load_v = 1'b1;

            rst_prev = i_rst;
            if (rst_left > 0) begin
                rst_next = 1'b1;
                rst_left--;
            end else if (n == 70) begin
                rst_next = 1'b1;
                rst_left = 1;
            end else if (n >= 120 && $urandom_range(0, 249) == 0) begin
                rst_next = 1'b1;
                rst_left = $urandom_range(0, 2);
            end else begin
                rst_next = 1'b0;
            end

            i_req  = req_v;
            i_dir  = dir_v;
            i_load = load_v;
            i_rst  = rst_next;

            if (rst_next) begin
                for (int k = n + 1; k <= n + SETTLE + 4; k++) begin
                    exp_ack[k]     = '0;
                    exp_plus[k]    = 1'b0;
                    exp_minus[k]   = 1'b0;
                    exp_drop[k]    = 1'b0;
                    exp_cnt_rst[k] = 1'b0;
                    exp_done[k]    = 1'b0;
                end
                idle_at = INF;
                last    = N_REQ - 1;
                ech     = PRESET;
                ch      = PRESET;
            end else if (rst_prev) begin
                exp_done[n + 1] = 1'b1;
                idle_at         = n + 2;
            end else if (n >= idle_at) begin
                if (load_v) begin
                    exp_cnt_rst[n + 1] = 1'b1;
                    exp_done[n + 3]    = 1'b1;
                    idle_at            = n + 4;
                    ech                = PRESET;
                end else if (req_v != '0) begin
                    w = -1;
                    for (int k = 1; k <= N_REQ; k++) begin
                        idx = (last + k) % N_REQ;
                        if (w < 0 && req_v[idx]) w = idx;
                    end
                    exp_ack[n + 1] = N_REQ'(1) << w;
                    last           = w;
                    if (dir_v[w]) begin
                        exp_plus[n + 1] = 1'b1;
                        ech             = (ech + 1) % MOD;
                    end else if (SAT && ech == 0) begin
                        exp_drop[n + 1] = 1'b1;
                    end else begin
                        exp_minus[n + 1] = 1'b1;
                        ech              = (ech + MOD - 1) % MOD;
                    end
                    idle_at = n + SETTLE + 2;
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
